// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one bus between instruction fetch and load/store.
// One outstanding transaction; load/store has priority, bounded by a fetch starvation guard.
module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // Fetch requester
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // Load/store requester
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  // Memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned   CW     = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CntMax = CW'(STARVE_MAX);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]    st_q, st_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic idle, any_req, sel_ls, accept, resp;

  always_comb begin
    idle    = (st_q == StIdle);
    any_req = if_req | ls_req;
    sel_ls  = ls_req & (~if_req | (cnt_q < CntMax));
    accept  = ~rst & idle & any_req & mem_ready;
    // Responses arriving while idle are stale and dropped.
    resp    = ~rst & ~idle & mem_rvalid;
  end

  always_comb begin
    mem_req   = ~rst & idle & any_req;
    mem_we    = ~rst & sel_ls & ls_we;
    mem_be    = rst ? '0 : (sel_ls ? ls_be : '1);
    mem_addr  = rst ? '0 : (sel_ls ? ls_addr : if_addr);
    mem_wdata = (rst | ~sel_ls) ? '0 : ls_wdata;
    if_gnt    = accept & ~sel_ls;
    ls_gnt    = accept & sel_ls;
    if_rvalid = resp & ~owner_q;
    ls_rvalid = resp & owner_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
    busy      = ~rst & ~idle;
  end

  always_comb begin
    st_d    = st_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      StIdle: begin
        if (accept) begin
          st_d    = StWait;
          owner_d = sel_ls;
          // Count only data grants that made a waiting fetch lose.
          if (sel_ls && if_req) begin
            cnt_d = (cnt_q == CntMax) ? CntMax : cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized traffic against a
// transaction-level model of arbitration, starvation bound and response routing.
module tb_mem_arbiter;

  localparam int unsigned SMax = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_out, m_own_ls, if_held, ls_held;
  int m_lat, starve;
  bit e_req, e_pick_ls, e_if_g, e_ls_g, e_if_rv, e_ls_rv;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMax)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One transaction with both requesters held high and a 1-cycle memory.
  task automatic xact(input bit exp_ls, input string tag);
    smp();
    chk({tag, "_ls_gnt"}, 32'(ls_gnt), 32'(exp_ls));
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'(!exp_ls));
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    smp();
    chk({tag, "_wait_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_ls_rv"}, 32'(ls_rvalid), 32'(exp_ls));
    chk({tag, "_if_rv"}, 32'(if_rvalid), 32'(!exp_ls));
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset with everything requesting
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; mem_ready = 1'b1;
    if_addr = 32'h0; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 32'h40; ls_wdata = 32'h55;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
    chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // First fetch after reset
    tick();
    rst = 1'b0; ls_req = 1'b0; if_addr = 32'h100; mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", 32'(mem_be), 32'hF);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    chk("f_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    smp();
    chk("f_busy", 32'(busy), 32'd1);
    chk("f_wait_req", 32'(mem_req), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("f_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("f_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("f_ls_rvalid", 32'(ls_rvalid), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk("f_if_rvalid_1cyc", 32'(if_rvalid), 32'd0);
    chk("f_if_rdata_zero", if_rdata, 32'd0);
    chk("f_busy_drop", 32'(busy), 32'd0);

    // Store acknowledge routing
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'h3; ls_addr = 32'h2000; ls_wdata = 32'h1234;
    smp();
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    chk("st_mem_addr", mem_addr, 32'h2000);
    chk("st_mem_wdata", mem_wdata, 32'h1234);
    chk("st_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    ls_req = 1'b0; mem_rvalid = 1'b1;
    smp();
    chk("st_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("st_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    mem_rvalid = 1'b0;

    // Priority and starvation bound
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h3000; if_addr = 32'h400;
    xact(1'b1, "sv1"); xact(1'b1, "sv2"); xact(1'b1, "sv3"); xact(1'b1, "sv4");
    xact(1'b0, "sv5"); xact(1'b1, "sv6");

    // Ready backpressure
    mem_ready = 1'b0; ls_addr = 32'h5000;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("bp_mem_req", 32'(mem_req), 32'd1);
      chk("bp_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      chk("bp_addr", mem_addr, 32'h5000);
      chk("bp_busy", 32'(busy), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    xact(1'b1, "bp_rel");
    if_req = 1'b0; ls_req = 1'b0;

    // Reset mid-WAIT, then a spurious response while idle
    if_req = 1'b1;
    smp();
    chk("rw_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    smp();
    chk("rw_busy", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    smp();
    chk("rw_busy_clr", 32'(busy), 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    smp();
    chk("rw_spur_rv", 32'({if_rvalid, ls_rvalid}), 32'd0);
    chk("rw_spur_rdata", if_rdata | ls_rdata, 32'd0);
    chk("rw_spur_busy", 32'(busy), 32'd0);
    tick();
    mem_rvalid = 1'b0;

    // Starvation count must restart from zero after a reset
    if_req = 1'b1; ls_req = 1'b1;
    xact(1'b1, "rc1"); xact(1'b1, "rc2"); xact(1'b1, "rc3");
    smp();
    chk("rc4_ls_gnt", 32'(ls_gnt), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    xact(1'b1, "rc5"); xact(1'b1, "rc6"); xact(1'b1, "rc7"); xact(1'b1, "rc8");
    xact(1'b0, "rc9");
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Randomized traffic against the transaction model
    m_out = 1'b0; starve = 0; if_held = 1'b0; ls_held = 1'b0; m_lat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (!if_held) begin
        if_req  = $urandom_range(0, 1) == 1;
        if_addr = $urandom;
      end
      if (!ls_held) begin
        ls_req   = $urandom_range(0, 1) == 1;
        ls_we    = $urandom_range(0, 1) == 1;
        ls_be    = 4'($urandom);
        ls_addr  = $urandom;
        ls_wdata = $urandom;
      end
      mem_ready  = $urandom_range(0, 3) != 0;
      mem_rvalid = m_out ? (m_lat == 0) : ($urandom_range(0, 9) == 0);
      mem_rdata  = $urandom;

      e_req     = !m_out && (if_req || ls_req);
      e_pick_ls = ls_req && (!if_req || starve < int'(SMax));
      e_if_g    = e_req && mem_ready && !e_pick_ls;
      e_ls_g    = e_req && mem_ready && e_pick_ls;
      e_if_rv   = m_out && mem_rvalid && !m_own_ls;
      e_ls_rv   = m_out && mem_rvalid && m_own_ls;

      smp();
      chk("rnd_mem_req", 32'(mem_req), 32'(e_req));
      chk("rnd_if_gnt", 32'(if_gnt), 32'(e_if_g));
      chk("rnd_ls_gnt", 32'(ls_gnt), 32'(e_ls_g));
      chk("rnd_if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("rnd_ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv));
      chk("rnd_if_rdata", if_rdata, e_if_rv ? mem_rdata : 32'd0);
      chk("rnd_ls_rdata", ls_rdata, e_ls_rv ? mem_rdata : 32'd0);
      chk("rnd_busy", 32'(busy), 32'(m_out));
      if (e_req) begin
        chk("rnd_mem_addr", mem_addr, e_pick_ls ? ls_addr : if_addr);
        chk("rnd_mem_we", 32'(mem_we), 32'(e_pick_ls && ls_we));
        chk("rnd_mem_be", 32'(mem_be), e_pick_ls ? 32'(ls_be) : 32'hF);
        chk("rnd_mem_wdata", mem_wdata, e_pick_ls ? ls_wdata : 32'd0);
      end

      if (m_out && mem_rvalid) m_out = 1'b0;
      else if (m_out) m_lat--;
      if (e_if_g || e_ls_g) begin
        m_out    = 1'b1;
        m_own_ls = e_pick_ls;
        m_lat    = $urandom_range(0, 2);
        starve   = (e_pick_ls && if_req) ? starve + 1 : 0;
      end
      if_held = if_req && !e_if_g;
      ls_held = ls_req && !e_ls_g;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
